rf_read_arbiter: RTL
====================

Name: rf_read_arbiter

Overview:
- Shares the Regfile's single read port between two requesters.
  - Requester 0: decode-stage operand fetch (priority).
  - Requester 1: debug/trace register-inspection unit (background).
- Fixed priority to requester 0, with a starvation guard that forces a grant to requester 1.
- Regfile read is combinational; the block registers read data and returns it one cycle after grant.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- MAX_WAIT, 4, consecutive denied cycles of requester 1 before a grant to it is forced (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- req0_i  input  1  requester 0 read request.
- addr0_i  input  ADDR_W  requester 0 register address.
- gnt0_o  output  1  requester 0 granted this cycle.
- valid0_o  output  1  requester 0 response valid (one-cycle pulse).
- data0_o  output  DATA_W  requester 0 response data.
- req1_i  input  1  requester 1 read request.
- addr1_i  input  ADDR_W  requester 1 register address.
- gnt1_o  output  1  requester 1 granted this cycle.
- valid1_o  output  1  requester 1 response valid (one-cycle pulse).
- data1_o  output  DATA_W  requester 1 response data.
- rf_re_o  output  1  Regfile read enable.
- rf_raddr_o  output  ADDR_W  Regfile read address.
- rf_rdata_i  input  DATA_W  Regfile read data, combinational from rf_raddr_o.

Behaviour:
- **Reset:** while rst=0, asynchronously clear all registers.
  - valid0_o=valid1_o=0, data0_o=data1_o=0, starve count=0.
  - Grant outputs are 0 while rst=0.
  - rf_re_o=0 and rf_raddr_o=0 while rst=0.
  - A read granted in the cycle reset asserts produces no response after reset releases.
- **Grant (combinational, same cycle as request):**
  - force1 = (starve == MAX_WAIT).
  - gnt1_o = req1_i & (force1 | ~req0_i).
  - gnt0_o = req0_i & ~gnt1_o.
  - At most one grant per cycle. No grant when neither requester is active.
- **Regfile drive:**
  - rf_re_o = gnt0_o | gnt1_o.
  - rf_raddr_o = addr of the granted requester; 0 when no grant.
- **Response (1-cycle latency):**
  - On a rising edge with gnt_k_o=1: data_k_o <= rf_rdata_i and valid_k_o <= 1.
  - Otherwise valid_k_o <= 0 and data_k_o holds its last value.
  - Back-to-back grants to the same port give back-to-back valid pulses, each carrying its own data.
- **Requester rule:** hold req_k_i and addr_k_i stable until gnt_k_o is seen; the request may change after.
  - A requester keeping req high after a grant is treated as a new request.
- **Starvation counter:** 4-bit, saturating at MAX_WAIT.
  - Increment when req1_i=1 and gnt1_o=0.
  - Clear when gnt1_o=1 or req1_i=0.
  - When force1 grants requester 1, requester 0 is denied that cycle; the decode stage stalls on ~gnt0_o.
- **Address 0:** no special handling; it is arbitrated like any address, and the Regfile returns zero.
- **Simultaneous requests:**
  - With starve < MAX_WAIT, requester 0 wins.
  - After MAX_WAIT consecutive losses, requester 1 wins exactly one cycle, then the count clears and requester 0 wins again.

Test Plan:
- **Reset:** rst=0 with req0_i=1, addr0_i=3 → all outputs 0. Release rst → next cycle gnt0_o=1, rf_raddr_o=3.
- **Single read:** req0_i=1 for one cycle, addr0_i=5, rf_rdata_i=32'h0000_ABCD → gnt0_o=1 same cycle; next cycle valid0_o=1, data0_o=32'h0000_ABCD; following cycle valid0_o=0, data held.
- **Priority:** req0_i and req1_i both high 1 cycle (starve=0) → gnt0_o=1, gnt1_o=0, starve becomes 1. Next cycle req0_i=0 → gnt1_o=1, starve clears.
- **Starvation:** req0_i and req1_i held high continuously, MAX_WAIT=4 → gnt0_o on cycles 1-4, gnt1_o on cycle 5 (gnt0_o=0), gnt0_o again on cycles 6-9, gnt1_o on cycle 10.
- **Back-to-back:** req1_i alone 3 cycles, addr1_i=1,2,3, rf_rdata_i=32'h11,32'h22,32'h33 → valid1_o high 3 consecutive cycles with data1_o=32'h11,32'h22,32'h33.
- **Reset mid-op:** grant to requester 1 at cycle N and rst=0 asserted before the edge → valid1_o stays 0 after release, data1_o=0.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// Shares the Regfile's single read port between decode operand fetch (priority)
// and a background debug/trace reader, with a starvation guard for the latter.
module rf_read_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              gnt0_o,
  output logic              valid0_o,
  output logic [DATA_W-1:0] data0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt1_o,
  output logic              valid1_o,
  output logic [DATA_W-1:0] data1_o,
  output logic              rf_re_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        starve_r;
  logic              force1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic [ADDR_W-1:0] raddr_s;
  logic              valid0_r;
  logic              valid1_r;
  logic [DATA_W-1:0] data0_r;
  logic [DATA_W-1:0] data1_r;

  // Grant decision; grants are suppressed while reset is held low.
  always_comb begin
    force1_s = (starve_r == MAX_WAIT_C);
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
    if (rst) begin
      gnt1_s = req1_i & (force1_s | ~req0_i);
      gnt0_s = req0_i & ~gnt1_s;
    end else begin
      gnt1_s = 1'b0;
      gnt0_s = 1'b0;
    end
  end

  // Regfile address mux; zero when the port is idle.
  always_comb begin
    raddr_s = {ADDR_W{1'b0}};
    case ({gnt1_s, gnt0_s})
      2'b01:   raddr_s = addr0_i;
      2'b10:   raddr_s = addr1_i;
      default: raddr_s = {ADDR_W{1'b0}};
    endcase
  end

  // Starvation counter: counts consecutive denied cycles of requester 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_r <= 4'd0;
    end else if (req1_i && !gnt1_s) begin
      if (starve_r < MAX_WAIT_C) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= 4'd0;
    end
  end

  // Response stage: capture read data one cycle after grant; data holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      data0_r  <= {DATA_W{1'b0}};
      data1_r  <= {DATA_W{1'b0}};
    end else begin
      valid0_r <= gnt0_s;
      valid1_r <= gnt1_s;
      if (gnt0_s) begin
        data0_r <= rf_rdata_i;
      end else begin
        data0_r <= data0_r;
      end
      if (gnt1_s) begin
        data1_r <= rf_rdata_i;
      end else begin
        data1_r <= data1_r;
      end
    end
  end

  assign gnt0_o     = gnt0_s;
  assign gnt1_o     = gnt1_s;
  assign rf_re_o    = gnt0_s | gnt1_s;
  assign rf_raddr_o = raddr_s;
  assign valid0_o   = valid0_r;
  assign valid1_o   = valid1_r;
  assign data0_o    = data0_r;
  assign data1_o    = data1_r;

endmodule
